// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around a decoder-based full-adder cell
// Optional SERIAL_ADDER_SUB_EN adds a sub port for a_in-b_in via inverted B and forced carry-in.

module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic [7:0] dec;

   // One-hot minterm decode; sum and carry are ORs of the matching minterms
   assign dec = 8'b0000_0001 << {a, b, ci};
   assign s   = dec[1] | dec[2] | dec[4] | dec[7];
   assign co  = dec[3] | dec[5] | dec[6] | dec[7];
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic               load, last;
   logic [WIDTH-1:0]   a_sh, b_sh, s_sh, s_next;
   logic               c_reg;
   logic [CNT_W-1:0]   cnt;
   logic               fa_sum, fa_carry;
   logic [WIDTH-1:0]   b_load;
   logic               c_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = sub ? ~b_in : b_in;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b_in;
   assign c_load = cin;
`endif

   serial_adder_fa u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (c_reg),
      .s  (fa_sum),
      .co (fa_carry)
   );

   assign s_next = {fa_sum, s_sh[WIDTH-1:1]};
   assign busy   = (state == RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         c_reg   <= 1'b0;
         cnt     <= '0;
         done    <= 1'b0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else begin
         done <= last;
         if (load) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            c_reg <= c_load;
            cnt   <= '0;
            s_sh  <= '0;
         end else if (state == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh  <= s_next;
            c_reg <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
         end
         // Result registers only move on the final bit, so they hold between completions
         if (last) begin
            sum_out <= s_next;
            cout    <= fa_carry;
         end
      end
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell, which is the team's decoder-based FA. The block feeds that cell LSB-first with operand bits and the registered carry, then consumes its sum and carry outputs. Sum bits are shifted into a result register and carry is fed back each cycle. Intended as a low-area adder where latency is acceptable; start/done handshake toward the controlling logic.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, latched when start accepted
b_in  input  WIDTH  operand B, latched when start accepted
cin  input  1  carry-in, latched when start accepted
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: sum_out/cout updated this cycle
sum_out  output  WIDTH  result, held until next completion
cout  output  1  final carry, held until next completion

Behaviour:
- Reset: clk and rst_n only; reset is synchronous active-low. On a clk edge with rst_n=0, state=IDLE. busy, done, sum_out and cout are 0. Internal shift registers, carry register and counter are 0.
- FSM states are IDLE and RUN.
- IDLE -> RUN on an edge with start=1:
  - a_sh<=a_in, b_sh<=b_in, c_reg<=cin, cnt<=0, s_sh<=0.
  - busy=1 from the following cycle.
- RUN, each edge:
  - FA inputs are a_sh[0], b_sh[0], c_reg.
  - s_sh <= {fa_sum, s_sh[WIDTH-1:1]}, i.e. right shift with the sum bit entering at the MSB.
  - a_sh and b_sh shift right with 0 fill.
  - c_reg <= fa_carry; cnt <= cnt+1.
- RUN -> IDLE on the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge):
  - sum_out <= {fa_sum, s_sh[WIDTH-1:1]}; cout <= fa_carry.
  - done<=1 for exactly one cycle; busy<=0.
- Latency: start sampled at edge E0 -> done and valid result visible after edge E0+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy=1 is ignored and not queued; operands are not re-latched.
- start=1 in the cycle done=1 is accepted (FSM is in IDLE), so back-to-back operations run with no gap.
- sum_out/cout change only on a done edge or reset; they are stable between completions.
- Arithmetic is modulo 2^WIDTH, with cout = bit WIDTH of a_in+b_in+cin.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs forced to 0, FSM returns to IDLE.
- a_in/b_in/cin changing after acceptance has no effect on the running operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands at start.
  - sub=1: b_sh<=~b_in, c_reg<=1 (cin ignored), so the result is a_in-b_in mod 2^WIDTH. cout=1 means no borrow (a_in>=b_in unsigned).
  - sub=0: identical to the base behaviour.
- Undefined: no sub port; addition only.

Test Plan:
- rst_n=0 for 2 edges after random activity -> busy=0, done=0, sum_out=0x00, cout=0.
- WIDTH=8, a_in=0x35, b_in=0x4A, cin=0, start pulse at E0 -> busy=1 for 8 cycles, done=1 after E0+8, sum_out=0x7F, cout=0.
- Boundary values:
  - a_in=0xFF, b_in=0x01, cin=0 -> sum_out=0x00, cout=1.
  - Back-to-back start in the done cycle with a_in=0xFF, b_in=0xFF, cin=1 -> second done 8 cycles later, sum_out=0xFF, cout=1.
- Start 0x10+0x20, then a second start with 0xAA+0x55 at E0+3 while busy -> second start ignored; single done at E0+8 with sum_out=0x30, cout=0; no further done.
- Start at E0, rst_n=0 at E0+4 -> busy=0 next cycle, no done pulse, sum_out=0x00. A fresh start afterwards completes normally in 8 cycles.
- SERIAL_ADDER_SUB_EN defined:
  - a_in=0x10, b_in=0x03, sub=1 -> sum_out=0x0D, cout=1.
  - a_in=0x03, b_in=0x10, sub=1 -> sum_out=0xF3, cout=0.
  - sub=0 with 0x35+0x4A -> 0x7F.
